// File: rtl/sseg_scan4_pkg.sv
// Shared seven-segment constants: active-low patterns in {g,f,e,d,c,b,a} order.
package sseg_scan4_pkg;

  // Bit 6 is segment g, bit 0 is segment a; a 0 lights the segment.
  typedef struct packed {
    logic g;
    logic f;
    logic e;
    logic d;
    logic c;
    logic b;
    logic a;
  } seg_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_OFF = 4'b1111;

endpackage

// File: rtl/bcd_to_sseg.sv
// bcd_to_sseg: 4-bit code to active-low segment pattern; codes 10-15 show a dash.
// Latency: combinational; no flow control.
module bcd_to_sseg
  import sseg_scan4_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (code)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/sseg_scan4.sv
// sseg_scan4: scans four digits onto a common-anode display with leading-zero blanking and anode guard.
// Latency: digit sampled at its slot tick, driven from the next cycle; free-running, no backpressure.
module sseg_scan4
  import sseg_scan4_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 16,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic       CLK,
  input  logic       R,
  input  logic [3:0] D0,
  input  logic [3:0] D1,
  input  logic [3:0] D2,
  input  logic [3:0] D3,
  input  logic [3:0] DP_IN,
  output logic [3:0] AN,
  output logic [6:0] SEG,
  output logic       DP,
  output logic       TICK
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_START = CNT_W'(REFRESH_DIV - GUARD);

  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       idx;
  logic             tick;
  logic [3:0]       slot_an, slot_an_nxt, an_nxt;
  logic [3:0]       digit;
  logic             dp_req, blank;
  logic             blank3, blank2, blank1;
  logic [6:0]       seg_dec;

  bcd_to_sseg u_dec (
    .code (digit),
    .seg  (seg_dec)
  );

  // A digit may only blank if everything to its left is blank too.
  assign blank3 = BLANK_LZ && (D3 == 4'd0) && !DP_IN[3];
  assign blank2 = blank3 && (D2 == 4'd0) && !DP_IN[2];
  assign blank1 = blank2 && (D1 == 4'd0) && !DP_IN[1];

  assign tick    = (cnt == CNT_MAX);
  assign cnt_nxt = tick ? '0 : cnt + 1'b1;

  always_comb begin
    digit  = D0;
    dp_req = DP_IN[0];
    blank  = 1'b0;
    case (idx)
      2'd0: begin digit = D0; dp_req = DP_IN[0]; blank = 1'b0;   end
      2'd1: begin digit = D1; dp_req = DP_IN[1]; blank = blank1; end
      2'd2: begin digit = D2; dp_req = DP_IN[2]; blank = blank2; end
      2'd3: begin digit = D3; dp_req = DP_IN[3]; blank = blank3; end
      default: ;
    endcase
  end

  always_comb begin
    slot_an_nxt = blank ? AN_OFF : ~(4'b0001 << idx);
    if (cnt_nxt >= GUARD_START)
      an_nxt = AN_OFF;
    else if (tick)
      an_nxt = slot_an_nxt;
    else
      an_nxt = slot_an;
  end

  always_ff @(posedge CLK) begin
    if (R) begin
      cnt     <= '0;
      idx     <= 2'd0;
      slot_an <= AN_OFF;
      AN      <= AN_OFF;
      SEG     <= SEG_BLANK;
      DP      <= 1'b1;
      TICK    <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      TICK <= tick;
      AN   <= an_nxt;
      if (tick) begin
        idx     <= idx + 2'd1;
        slot_an <= slot_an_nxt;
        SEG     <= seg_dec;
        DP      <= ~dp_req;
      end
    end
  end

endmodule

// File: tb/tb_sseg_scan4.sv
// Scoreboard bench for sseg_scan4 with an 8-cycle slot and a 2-cycle guard.
module tb_sseg_scan4;

  localparam int DIV = 8;
  localparam int GRD = 2;

  logic       CLK = 1'b0;
  logic       R   = 1'b1;
  logic [3:0] D0 = 4'd0, D1 = 4'd0, D2 = 4'd0, D3 = 4'd0;
  logic [3:0] DP_IN = 4'd0;
  logic [3:0] AN;
  logic [6:0] SEG;
  logic       DP;
  logic       TICK;

  always #5 CLK = ~CLK;

  sseg_scan4 #(
    .REFRESH_DIV (DIV),
    .GUARD       (GRD),
    .BLANK_LZ    (1'b1)
  ) dut (
    .CLK   (CLK),
    .R     (R),
    .D0    (D0),
    .D1    (D1),
    .D2    (D2),
    .D3    (D3),
    .DP_IN (DP_IN),
    .AN    (AN),
    .SEG   (SEG),
    .DP    (DP),
    .TICK  (TICK)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  localparam exp_t OFF = {4'b1111, 7'b1111111, 1'b1};

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  logic r_q    = 1'b0;

  always @(posedge CLK) r_q <= R;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [3:0] an, input logic [6:0] seg, input logic dp);
    q.push_back({an, seg, dp});
  endtask

  task automatic set_d(input logic [3:0] d3, input logic [3:0] d2, input logic [3:0] d1,
                       input logic [3:0] d0, input logic [3:0] dp);
    D3 = d3; D2 = d2; D1 = d1; D0 = d0; DP_IN = dp;
  endtask

  task automatic wait_tick(output int cyc);
    cyc = 0;
    do begin
      @(negedge CLK);
      cyc++;
    end while (TICK !== 1'b1 && cyc < 4 * DIV);
    if (TICK !== 1'b1) begin
      n_chk++;
      n_fail++;
      $display("FAIL tick_timeout: no TICK within %0d cycles at %0t", cyc, $time);
    end
  endtask

  // Monitor: each TICK opens a slot whose expected outputs come from the queue.
  initial begin
    exp_t cur;
    int   phase;
    cur   = OFF;
    phase = DIV;
    forever begin
      @(negedge CLK);
      if (r_q) begin
        cur   = OFF;
        phase = DIV;
        check("reset_tick", 32'(TICK), 32'(1'b0));
      end else if (TICK === 1'b1) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_tick: got TICK with empty queue, expected none at %0t", $time);
          cur = OFF;
        end else begin
          cur = q.pop_front();
        end
        phase = 0;
      end
      check("an", 32'(AN), 32'((phase < DIV - GRD) ? cur.an : 4'b1111));
      check("seg", 32'(SEG), 32'(cur.seg));
      check("dp", 32'(DP), 32'(cur.dp));
      if (phase < DIV) phase++;
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;

    // Reset for three cycles, then scan 4,3,2,1 twice.
    R = 1'b1;
    set_d(4'd4, 4'd3, 4'd2, 4'd1, 4'b0000);
    repeat (3) @(negedge CLK);
    R = 1'b0;
    repeat (2) begin
      push(4'b1110, 7'b1111001, 1'b1);
      push(4'b1101, 7'b0100100, 1'b1);
      push(4'b1011, 7'b0110000, 1'b1);
      push(4'b0111, 7'b0011001, 1'b1);
    end
    wait_tick(cyc);
    check("first_tick_delay", 32'(cyc), 32'(8));
    repeat (7) wait_tick(cyc);

    // Leading-zero blanking: 0,0,5,0.
    set_d(4'd0, 4'd0, 4'd5, 4'd0, 4'b0000);
    push(4'b1110, 7'b1000000, 1'b1);
    push(4'b1101, 7'b0010010, 1'b1);
    push(4'b1111, 7'b1000000, 1'b1);
    push(4'b1111, 7'b1000000, 1'b1);
    repeat (4) wait_tick(cyc);

    // All zero: only digit 0 lit.
    set_d(4'd0, 4'd0, 4'd0, 4'd0, 4'b0000);
    push(4'b1110, 7'b1000000, 1'b1);
    push(4'b1111, 7'b1000000, 1'b1);
    push(4'b1111, 7'b1000000, 1'b1);
    push(4'b1111, 7'b1000000, 1'b1);
    repeat (4) wait_tick(cyc);

    // Decimal point on digit 2 stops blanking there; code 12 shows a dash.
    set_d(4'd0, 4'd0, 4'd0, 4'd12, 4'b0100);
    push(4'b1110, 7'b0111111, 1'b1);
    push(4'b1101, 7'b1000000, 1'b1);
    push(4'b1011, 7'b1000000, 1'b0);
    push(4'b1111, 7'b1000000, 1'b1);
    repeat (4) wait_tick(cyc);

    // D1 changes 3 -> 7 at cnt=3 of slot 1; visible only on the next slot-1 pass.
    set_d(4'd0, 4'd0, 4'd3, 4'd0, 4'b0000);
    push(4'b1110, 7'b1000000, 1'b1);
    push(4'b1101, 7'b0110000, 1'b1);
    push(4'b1111, 7'b1000000, 1'b1);
    push(4'b1111, 7'b1000000, 1'b1);
    push(4'b1110, 7'b1000000, 1'b1);
    push(4'b1101, 7'b1111000, 1'b1);
    repeat (2) wait_tick(cyc);
    repeat (3) @(negedge CLK);
    D1 = 4'd7;
    repeat (4) wait_tick(cyc);

    // One-cycle reset at cnt=4 of slot 2 while digit 2 is lit.
    set_d(4'd0, 4'd8, 4'd7, 4'd0, 4'b0000);
    push(4'b1011, 7'b0000000, 1'b1);
    wait_tick(cyc);
    repeat (4) @(negedge CLK);
    R = 1'b1;
    @(negedge CLK);
    R = 1'b0;
    push(4'b1110, 7'b1000000, 1'b1);
    push(4'b1101, 7'b1111000, 1'b1);
    wait_tick(cyc);
    check("tick_after_midreset", 32'(cyc), 32'(8));
    wait_tick(cyc);

    repeat (3) @(negedge CLK);
    check("queue_drained", 32'(q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sseg_scan4.md
Name: sseg_scan4

Overview:
- Downstream consumer of the BCD counter chain (mod-6/mod-10 time digits).
- Time-multiplexes four 4-bit digit values onto a common-anode 4-digit seven-segment display.
- Provides a refresh prescaler, anode rotation, BCD-to-segment decode, leading-zero blanking, decimal points and an anti-ghosting guard interval.
- All outputs are registered and drive board pins directly.

Parameters:
- REFRESH_DIV, 50000: clock cycles per digit slot. Legal range is REFRESH_DIV >= GUARD+2.
- GUARD, 16: cycles at the end of each slot during which all anodes are off.
- BLANK_LZ, 1: 1 enables leading-zero blanking; 0 always shows all four digits.

Ports:
- CLK  input  1  system clock.
- R  input  1  reset, synchronous, active-high.
- D0  input  4  digit 0 (rightmost) value.
- D1  input  4  digit 1 value.
- D2  input  4  digit 2 value.
- D3  input  4  digit 3 (leftmost) value.
- DP_IN  input  4  decimal point request per digit; bit k maps to digit k; 1 = lit.
- AN  output  4  anode enables, active-low; bit k maps to digit k.
- SEG  output  7  segments {g,f,e,d,c,b,a}, active-low.
- DP  output  1  decimal point, active-low.
- TICK  output  1  one-cycle pulse at each slot boundary (debug and bench use).

Behaviour:
- Reset (R=1 at a CLK edge):
  - Next state: cnt=0, idx=0, AN=4'b1111, SEG=7'b1111111, DP=1, TICK=0.
  - R has priority over every other event, including mid-slot and on a tick cycle.
- Prescaler:
  - cnt counts 0..REFRESH_DIV-1 and wraps to 0.
  - tick = (cnt == REFRESH_DIV-1).
  - TICK is a registered copy of tick, high for exactly one cycle.
- Slot load, on the edge where tick=1:
  - Latch D[idx], DP_IN[idx] and the blank decision for idx into the output registers.
  - idx <= idx+1, wrapping 3 -> 0.
  - After reset, the first tick loads digit 0. The order is then 0,1,2,3,0,...
- Input sampling:
  - Digit inputs are sampled only at the tick edge.
  - Changes within a slot do not alter the displayed digit until its next slot (no tearing).
- Latency: AN/SEG/DP reflect slot k from the edge after its tick until the next tick edge.
- Guard interval:
  - While cnt >= REFRESH_DIV-GUARD, AN is forced to 4'b1111.
  - SEG and DP hold their values during the guard.
  - The first slot after reset is fully dark, since AN is 1111 from reset until the first tick.
- Anode drive: outside the guard, AN = ~(1 << slot) for a non-blanked slot, else 4'b1111.
- Decode (active-low, {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Codes 10-15 decode to a dash, 0111111.
- Leading-zero blanking (BLANK_LZ=1):
  - Digit 3 is blank if D3==0 and DP_IN[3]==0.
  - Digit 2 is blank if digit 3 is blank, D2==0 and DP_IN[2]==0.
  - Digit 1 follows the same rule relative to digit 2.
  - Digit 0 is never blanked.
  - The decision is evaluated on the input values sampled at that slot's tick.
- DP = ~DP_IN[slot] latched at the tick. A lit DP stops blanking at and to the right of that digit.
- No combinational path from any input to any output.

Decomposition:
- Shared package holds:
  - segment pattern constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK;
  - the SEG bit-order definition;
  - AN_OFF = 4'b1111.
- One sub-module, bcd_to_sseg: combinational 4-bit code -> 7-bit active-low pattern. It is reused by other display blocks.
- Prescaler, index, blanking and output registers stay in sseg_scan4.

Test Plan (REFRESH_DIV=8, GUARD=2, BLANK_LZ=1 unless stated):
- Reset:
  - Stimulus: R=1 for 3 cycles, then release.
  - Required: AN=1111, SEG=1111111, DP=1 throughout reset and until the first TICK, 8 cycles after release.
- Scan order:
  - Stimulus: D3..D0=4,3,2,1, BLANK_LZ=0.
  - Required: successive slots give AN=1110/SEG=1111001, AN=1101/0100100, AN=1011/0110000, AN=0111/0011001.
  - Each slot's AN is active for 6 cycles, then 1111 for 2 cycles; the sequence repeats.
- Blanking:
  - Stimulus: D3..D0=0,0,5,0.
  - Required: slots 3 and 2 keep AN=1111; slot 1 gives SEG=0010010; slot 0 gives SEG=1000000.
  - Stimulus: all zero.
  - Required: only digit 0 is lit, showing 1000000.
- DP and invalid code:
  - Stimulus: DP_IN=0100, D3..D0=0,0,0,12.
  - Required: slot 2 gives AN=1011, SEG=1000000, DP=0; slot 0 gives dash 0111111; slot 3 is blank.
- Mid-slot input change:
  - Stimulus: change D1 from 3 to 7 at cnt=3 of slot 1.
  - Required: slot 1 shows 0110000 for its full duration; the next slot-1 pass shows 1111000.
- Reset mid-operation:
  - Stimulus: assert R for 1 cycle at cnt=4 of slot 2.
  - Required: outputs are all-off on the next edge; after release the first TICK comes 8 cycles later and loads digit 0.
